aes_round_ctrl: RTL and testbench

//   Round sequencer for the AES-128 encrypt datapath. Accepts a start request, then walks the

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_step_timer.sv | 28 ++
 rtl/aes_round_ctrl.sv | 116 +++++++++++
 tb/tb_aes_round_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES step codes, round count and default step latencies
package aes_pkg;

    localparam logic [2:0] STEP_IDLE          = 3'b000;
    localparam logic [2:0] STEP_LOAD          = 3'b001;
    localparam logic [2:0] STEP_SUB_BYTES     = 3'b010;
    localparam logic [2:0] STEP_SHIFT_ROWS    = 3'b011;
    localparam logic [2:0] STEP_MIX_COLUMNS   = 3'b100;
    localparam logic [2:0] STEP_ADD_ROUND_KEY = 3'b101;
    localparam logic [2:0] STEP_DONE          = 3'b110;

    localparam int AES_NR      = 10;
    localparam int AES_SB_LAT  = 3;
    localparam int AES_SR_LAT  = 1;
    localparam int AES_MC_LAT  = 1;
    localparam int AES_ARK_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE          = STEP_IDLE,
        ST_LOAD          = STEP_LOAD,
        ST_SUB_BYTES     = STEP_SUB_BYTES,
        ST_SHIFT_ROWS    = STEP_SHIFT_ROWS,
        ST_MIX_COLUMNS   = STEP_MIX_COLUMNS,
        ST_ADD_ROUND_KEY = STEP_ADD_ROUND_KEY,
        ST_DONE          = STEP_DONE
    } aes_state_e;

    function automatic int max_lat(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/aes_step_timer.sv
// rtl/aes_step_timer.sv - loadable down-counter flagging the last cycle of a step
module aes_step_timer #(
    parameter int CW = 3
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          enable,
    output logic          last
);

    logic [CW-1:0] count;

    // Loaded with LAT-1 on step entry, so a count of zero marks the capture cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 encrypt round sequencer (FSM, round counter, step strobes)
// Optional abort input enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter int SB_LAT  = AES_SB_LAT,
    parameter int SR_LAT  = AES_SR_LAT,
    parameter int MC_LAT  = AES_MC_LAT,
    parameter int ARK_LAT = AES_ARK_LAT
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic       i_abort,
`endif
    output logic       o_ready,
    output logic       o_done,
    output logic       o_load_input,
    output logic [2:0] o_step,
    output logic [3:0] o_round,
    output logic       o_sub_bytes_active,
    output logic       o_shift_rows_active,
    output logic       o_mix_columns_active,
    output logic       o_add_round_key_active,
    output logic       o_capture,
    output logic       o_key_round_en
);

    localparam int         CW   = $clog2(max_lat(SB_LAT, SR_LAT, MC_LAT, ARK_LAT)) + 1;
    localparam logic [3:0] NR_R = 4'(NR);

    aes_state_e    state, state_next;
    logic [3:0]    round;
    logic          in_step;
    logic          step_last;
    logic          timer_load;
    logic [CW-1:0] timer_value;
    logic          more_rounds;

    assign more_rounds = (round < NR_R);
    assign in_step     = (state == ST_SUB_BYTES) || (state == ST_SHIFT_ROWS) ||
                         (state == ST_MIX_COLUMNS) || (state == ST_ADD_ROUND_KEY);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:          if (i_start) state_next = ST_LOAD;
            ST_LOAD:          state_next = ST_ADD_ROUND_KEY;
            ST_SUB_BYTES:     if (step_last) state_next = ST_SHIFT_ROWS;
            ST_SHIFT_ROWS:    if (step_last) state_next = more_rounds ? ST_MIX_COLUMNS : ST_ADD_ROUND_KEY;
            ST_MIX_COLUMNS:   if (step_last) state_next = ST_ADD_ROUND_KEY;
            ST_ADD_ROUND_KEY: if (step_last) state_next = more_rounds ? ST_SUB_BYTES : ST_DONE;
            ST_DONE:          state_next = ST_IDLE;
            default:          state_next = ST_IDLE;
        endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
        if (i_abort) state_next = ST_IDLE;
`endif
    end

    // Timer is reloaded on every state change with the latency of the state being entered.
    always_comb begin
        timer_load  = (state_next != state);
        timer_value = '0;
        case (state_next)
            ST_SUB_BYTES:     timer_value = CW'(SB_LAT - 1);
            ST_SHIFT_ROWS:    timer_value = CW'(SR_LAT - 1);
            ST_MIX_COLUMNS:   timer_value = CW'(MC_LAT - 1);
            ST_ADD_ROUND_KEY: timer_value = CW'(ARK_LAT - 1);
            default:          timer_value = '0;
        endcase
    end

    aes_step_timer #(.CW(CW)) u_step_timer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (in_step),
        .last       (step_last)
    );

    // Round holds NR through DONE and clears on any return to IDLE.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            round <= '0;
        end else if (state_next == ST_IDLE) begin
            round <= '0;
        end else if (o_key_round_en) begin
            round <= round + 4'd1;
        end
    end

    assign o_ready                = (state == ST_IDLE);
    assign o_done                 = (state == ST_DONE);
    assign o_load_input           = (state == ST_LOAD);
    assign o_step                 = state;
    assign o_round                = round;
    assign o_sub_bytes_active     = (state == ST_SUB_BYTES);
    assign o_shift_rows_active    = (state == ST_SHIFT_ROWS);
    assign o_mix_columns_active   = (state == ST_MIX_COLUMNS);
    assign o_add_round_key_active = (state == ST_ADD_ROUND_KEY);
    assign o_capture              = in_step && step_last;
    assign o_key_round_en         = o_capture && (state == ST_ADD_ROUND_KEY) && more_rounds;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed self-checking bench for aes_round_ctrl
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       abort = 1'b0;
    logic       sel = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       d1_ready, d1_done, d1_load, d1_sb, d1_sr, d1_mc, d1_ark, d1_cap, d1_key;
    logic [2:0] d1_step;
    logic [3:0] d1_round;
    logic       d2_ready, d2_done, d2_load, d2_sb, d2_sr, d2_mc, d2_ark, d2_cap, d2_key;
    logic [2:0] d2_step;
    logic [3:0] d2_round;

    always #5 clk = ~clk;

    aes_round_ctrl dut1 (
        .i_clock(clk), .i_reset(reset), .i_start(start1),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .i_abort(abort),
`endif
        .o_ready(d1_ready), .o_done(d1_done), .o_load_input(d1_load), .o_step(d1_step),
        .o_round(d1_round), .o_sub_bytes_active(d1_sb), .o_shift_rows_active(d1_sr),
        .o_mix_columns_active(d1_mc), .o_add_round_key_active(d1_ark),
        .o_capture(d1_cap), .o_key_round_en(d1_key)
    );

    aes_round_ctrl #(.SB_LAT(1), .MC_LAT(2)) dut2 (
        .i_clock(clk), .i_reset(reset), .i_start(start2),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .i_abort(1'b0),
`endif
        .o_ready(d2_ready), .o_done(d2_done), .o_load_input(d2_load), .o_step(d2_step),
        .o_round(d2_round), .o_sub_bytes_active(d2_sb), .o_shift_rows_active(d2_sr),
        .o_mix_columns_active(d2_mc), .o_add_round_key_active(d2_ark),
        .o_capture(d2_cap), .o_key_round_en(d2_key)
    );

    logic       m_done, m_load, m_sb, m_mc, m_cap, m_key;
    logic [2:0] m_step;
    logic [3:0] m_round;
    always_comb begin
        m_done  = sel ? d2_done  : d1_done;
        m_load  = sel ? d2_load  : d1_load;
        m_sb    = sel ? d2_sb    : d1_sb;
        m_mc    = sel ? d2_mc    : d1_mc;
        m_cap   = sel ? d2_cap   : d1_cap;
        m_key   = sel ? d2_key   : d1_key;
        m_step  = sel ? d2_step  : d1_step;
        m_round = sel ? d2_round : d1_round;
    end

    // Results of the most recent run_op
    int         r_lat, r_caps, r_keys, r_sb, r_mc_visits, r_mc_maxrun, r_mc_last_round;
    logic [3:0] r_round_done;
    logic [2:0] tr_step [0:200];
    logic [3:0] tr_round [0:200];
    logic       tr_load [0:200];

    // Starts one operation on the selected DUT from IDLE; returns on the o_done negedge.
    task automatic run_op(input logic use2);
        int run;
        logic prev_mc;
        sel = use2;
        r_lat = -1; r_caps = 0; r_keys = 0; r_sb = 0; r_mc_visits = 0; r_mc_maxrun = 0;
        r_mc_last_round = 0; r_round_done = 4'hf; run = 0; prev_mc = 1'b0;
        if (use2) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            tr_step[c] = m_step; tr_round[c] = m_round; tr_load[c] = m_load;
            r_caps += int'(m_cap);
            r_keys += int'(m_key);
            r_sb   += int'(m_sb);
            if (m_mc && !prev_mc) r_mc_visits++;
            if (m_mc && m_round == 4'd10) r_mc_last_round++;
            run = m_mc ? run + 1 : 0;
            if (run > r_mc_maxrun) r_mc_maxrun = run;
            prev_mc = m_mc;
            if (m_done) begin
                r_lat = c;
                r_round_done = m_round;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (d1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", d1_ready); end
        checks++; if (d1_step !== 3'b000) begin errors++; $display("FAIL reset_step got %b want 000", d1_step); end
        checks++; if (d1_round !== 4'd0) begin errors++; $display("FAIL reset_round got %0d want 0", d1_round); end
        checks++;
        if ({d1_done, d1_load, d1_sb, d1_sr, d1_mc, d1_ark, d1_cap, d1_key} !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000000",
                     {d1_done, d1_load, d1_sb, d1_sr, d1_mc, d1_ark, d1_cap, d1_key});
        end
    endtask

    task automatic test_single_op;
        run_op(1'b0);
        checks++; if (tr_load[1] !== 1'b1) begin errors++; $display("FAIL load_at_t1 got %b want 1", tr_load[1]); end
        checks++; if (r_lat != 62) begin errors++; $display("FAIL latency got %0d want 62", r_lat); end
        checks++; if (r_round_done !== 4'd10) begin errors++; $display("FAIL round_at_done got %0d want 10", r_round_done); end
        checks++; if (r_keys != 10) begin errors++; $display("FAIL key_pulses got %0d want 10", r_keys); end
        @(negedge clk);
        checks++; if (d1_ready !== 1'b1 || d1_round !== 4'd0) begin
            errors++; $display("FAIL after_done got ready=%b round=%0d want ready=1 round=0", d1_ready, d1_round);
        end
    endtask

    task automatic test_step_trace;
        int         ec [13] = '{1, 2, 3, 5, 6, 7, 8, 9, 56, 57, 60, 61, 62};
        logic [2:0] es [13] = '{3'd1, 3'd5, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd5, 3'd2, 3'd3, 3'd5, 3'd6};
        int         er [13] = '{0, 0, 1, 1, 1, 1, 1, 2, 9, 10, 10, 10, 10};
        run_op(1'b0);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (tr_step[ec[i]] !== es[i] || tr_round[ec[i]] !== 4'(er[i])) begin
                errors++;
                $display("FAIL trace_c%0d got step=%0d round=%0d want step=%0d round=%0d",
                         ec[i], tr_step[ec[i]], tr_round[ec[i]], es[i], er[i]);
            end
        end
        checks++; if (r_sb != 30) begin errors++; $display("FAIL sb_cycles got %0d want 30", r_sb); end
        checks++; if (r_mc_visits != 9) begin errors++; $display("FAIL mc_visits got %0d want 9", r_mc_visits); end
        checks++; if (r_mc_last_round != 0) begin errors++; $display("FAIL mc_in_round10 got %0d want 0", r_mc_last_round); end
        checks++; if (r_caps != 40) begin errors++; $display("FAIL capture_pulses got %0d want 40", r_caps); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int nd;
        int dt [3];
        nd = 0; dt = '{0, 0, 0};
        start1 = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (d1_done) begin
                if (nd < 3) dt[nd] = c;
                nd++;
            end
        end
        start1 = 1'b0;
        // Each operation is 62 cycles plus one IDLE cycle where the held start is taken.
        checks++; if (nd != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nd); end
        checks++; if (dt[0] != 62) begin errors++; $display("FAIL b2b_done0 got %0d want 62", dt[0]); end
        checks++; if (dt[1] != 125) begin errors++; $display("FAIL b2b_done1 got %0d want 125", dt[1]); end
        checks++; if (dt[2] != 188) begin errors++; $display("FAIL b2b_done2 got %0d want 188", dt[2]); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic found;
        int   nd;
        found = 1'b0; nd = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= 100 && !found; c++) begin
            if (d1_mc && d1_round == 4'd5) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL reach_r5_mc got 0 want 1"); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (d1_ready !== 1'b1 || d1_step !== 3'd0 || d1_round !== 4'd0) begin
            errors++; $display("FAIL mid_reset_state got ready=%b step=%0d round=%0d want 1 0 0", d1_ready, d1_step, d1_round);
        end
        checks++; if ({d1_done, d1_load, d1_sb, d1_sr, d1_mc, d1_ark, d1_cap, d1_key} !== 8'h00) begin
            errors++; $display("FAIL mid_reset_strobes got %b want 00000000",
                               {d1_done, d1_load, d1_sb, d1_sr, d1_mc, d1_ark, d1_cap, d1_key});
        end
        for (int c = 0; c < 70; c++) begin
            if (d1_done) nd++;
            @(negedge clk);
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL mid_reset_no_done got %0d want 0", nd); end
        run_op(1'b0);
        checks++; if (r_lat != 62) begin errors++; $display("FAIL restart_latency got %0d want 62", r_lat); end
        @(negedge clk);
    endtask

    task automatic test_lat_override;
        run_op(1'b1);
        // 1 LOAD + 1 ARK + 9 x (1+1+2+1) + (1+1+1) + 1 DONE
        checks++; if (r_lat != 51) begin errors++; $display("FAIL ovr_latency got %0d want 51", r_lat); end
        checks++; if (r_mc_maxrun != 2) begin errors++; $display("FAIL ovr_mc_span got %0d want 2", r_mc_maxrun); end
        checks++; if (r_sb != 10) begin errors++; $display("FAIL ovr_sb_cycles got %0d want 10", r_sb); end
        checks++; if (r_caps != 40) begin errors++; $display("FAIL ovr_captures got %0d want 40", r_caps); end
        sel = 1'b0;
        @(negedge clk);
    endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
    task automatic test_abort;
        logic found;
        int   nd;
        found = 1'b0; nd = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= 100 && !found; c++) begin
            if (d1_sr && d1_round == 4'd3) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL reach_r3_sr got 0 want 1"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (d1_ready !== 1'b1 || d1_round !== 4'd0 || d1_sr !== 1'b0) begin
            errors++; $display("FAIL abort_state got ready=%b round=%0d sr=%b want 1 0 0", d1_ready, d1_round, d1_sr);
        end
        for (int c = 0; c < 70; c++) begin
            if (d1_done) nd++;
            @(negedge clk);
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", nd); end
        run_op(1'b0);
        abort = 1'b1;
        #1;
        checks++; if (d1_done !== 1'b1 || r_lat != 62) begin
            errors++; $display("FAIL abort_in_done got done=%b lat=%0d want 1 62", d1_done, r_lat);
        end
        @(negedge clk);
        abort = 1'b0;
        checks++; if (d1_ready !== 1'b1 || d1_round !== 4'd0) begin
            errors++; $display("FAIL abort_after_done got ready=%b round=%0d want 1 0", d1_ready, d1_round);
        end
        start1 = 1'b1; abort = 1'b1;
        @(negedge clk);
        start1 = 1'b0; abort = 1'b0;
        checks++; if (d1_ready !== 1'b1 || d1_load !== 1'b0) begin
            errors++; $display("FAIL abort_beats_start got ready=%b load=%b want 1 0", d1_ready, d1_load);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single_op;
        test_step_trace;
        test_back_to_back;
        test_reset_mid;
        test_lat_override;
`ifdef AES_ROUND_CTRL_ABORT_EN
        test_abort;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
